// File: rtl/cafeteira_comando.sv
// rtl/cafeteira_comando.sv - byte-stream command frame parser (HEADER, OP, ARG[, CHK])
// Optional XOR checksum byte enabled by macro CAFETEIRA_CHECKSUM_EN.
module cafeteira_comando #(
  parameter int unsigned TIMEOUT = 50000,
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter logic [7:0]  CMD_MAX = 8'h05
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pronto,
  input  logic [7:0] dados,
  input  logic       ack,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_arg,
  output logic       erro,
  output logic [1:0] erro_cod
);

  localparam logic [1:0]  ERR_CMD      = 2'b00;
`ifdef CAFETEIRA_CHECKSUM_EN
  localparam logic [1:0]  ERR_CHK      = 2'b01;
`endif
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0]  ERR_OVERRUN  = 2'b11;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

`ifdef CAFETEIRA_CHECKSUM_EN
  typedef enum logic [1:0] {OCIOSO, OP, ARG, CHK} state_t;
`else
  typedef enum logic [1:0] {OCIOSO, OP, ARG} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
`ifdef CAFETEIRA_CHECKSUM_EN
  logic [7:0]  arg_q, arg_d;
  logic        chk_ok;
`endif
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_op_q, cmd_op_d;
  logic [7:0]  cmd_arg_q, cmd_arg_d;
  logic        erro_q, erro_d;
  logic [1:0]  erro_cod_q, erro_cod_d;

  logic        frame_done;
  logic [7:0]  frame_arg;
  logic        op_legal;
  logic        timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCIOSO;
      cnt_q       <= 16'h0000;
      op_q        <= 8'h00;
`ifdef CAFETEIRA_CHECKSUM_EN
      arg_q       <= 8'h00;
`endif
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 8'h00;
      cmd_arg_q   <= 8'h00;
      erro_q      <= 1'b0;
      erro_cod_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
`ifdef CAFETEIRA_CHECKSUM_EN
      arg_q       <= arg_d;
`endif
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_arg_q   <= cmd_arg_d;
      erro_q      <= erro_d;
      erro_cod_q  <= erro_cod_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
`ifdef CAFETEIRA_CHECKSUM_EN
    arg_d       = arg_q;
    chk_ok      = 1'b1;
`endif
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_arg_d   = cmd_arg_q;
    erro_d      = 1'b0;
    erro_cod_d  = 2'b00;
    frame_done  = 1'b0;
    frame_arg   = dados;

    // A byte always beats a simultaneous timeout expiry.
    timeout_hit = (state_q != OCIOSO) && !pronto && (cnt_q == TIMEOUT_LAST);

    if (pronto || state_q == OCIOSO) begin
      cnt_d = 16'h0000;
    end else begin
      cnt_d = cnt_q + 16'h0001;
    end

    if (cmd_valid_q && ack) begin
      cmd_valid_d = 1'b0;
    end

    if (pronto) begin
      case (state_q)
        OCIOSO: begin
          if (dados == HEADER) begin
            state_d = OP;
          end
        end
        OP: begin
          op_d    = dados;
          state_d = ARG;
        end
`ifdef CAFETEIRA_CHECKSUM_EN
        ARG: begin
          arg_d   = dados;
          state_d = CHK;
        end
        CHK: begin
          frame_done = 1'b1;
          frame_arg  = arg_q;
          chk_ok     = (dados == (op_q ^ arg_q));
          state_d    = OCIOSO;
        end
`else
        ARG: begin
          frame_done = 1'b1;
          frame_arg  = dados;
          state_d    = OCIOSO;
        end
`endif
        default: state_d = OCIOSO;
      endcase
    end else if (timeout_hit) begin
      state_d    = OCIOSO;
      erro_d     = 1'b1;
      erro_cod_d = ERR_TIMEOUT;
    end

    op_legal = (op_q != 8'h00) && (op_q <= CMD_MAX);

    // Checksum error outranks illegal opcode; overrun only for otherwise valid frames.
    if (frame_done) begin
`ifdef CAFETEIRA_CHECKSUM_EN
      if (!chk_ok) begin
        erro_d     = 1'b1;
        erro_cod_d = ERR_CHK;
      end else
`endif
      if (!op_legal) begin
        erro_d     = 1'b1;
        erro_cod_d = ERR_CMD;
      end else if (cmd_valid_q && !ack) begin
        erro_d     = 1'b1;
        erro_cod_d = ERR_OVERRUN;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = op_q;
        cmd_arg_d   = frame_arg;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_arg   = cmd_arg_q;
  assign erro      = erro_q;
  assign erro_cod  = erro_cod_q;

endmodule

// File: tb/tb_cafeteira_comando.sv
// tb/tb_cafeteira_comando.sv - directed and random checks of cafeteira_comando against a queue model
module tb_cafeteira_comando;

`ifdef CAFETEIRA_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif
  localparam int         TOUT = 20;
  localparam logic [7:0] HDR  = 8'hAA;
  localparam logic [7:0] CMAX = 8'h05;

  logic       clock = 1'b0;
  logic       reset, pronto, ack;
  logic [7:0] dados;
  logic       cmd_valid, erro;
  logic [7:0] cmd_op, cmd_arg;
  logic [1:0] erro_cod;

  int tests = 0;
  int fails = 0;

  cafeteira_comando #(.TIMEOUT(TOUT), .HEADER(HDR), .CMD_MAX(CMAX)) dut (
    .clock(clock), .reset(reset), .pronto(pronto), .dados(dados), .ack(ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .erro(erro), .erro_cod(erro_cod)
  );

  always #5 clock = ~clock;

  // Reference: bytes of the current frame in a queue, idle cycles since the last byte.
  logic [7:0] frame[$];
  int         idle;
  logic       exp_valid, exp_erro, m_was;
  logic [7:0] exp_op, exp_arg, f_op, f_arg;
  logic [1:0] exp_cod;

  always @(posedge clock) begin
    exp_erro = 1'b0;
    exp_cod  = 2'b00;
    if (reset) begin
      frame.delete();
      idle = 0; exp_valid = 1'b0; exp_op = 8'h00; exp_arg = 8'h00;
    end else begin
      m_was = exp_valid;
      if (m_was && ack) exp_valid = 1'b0;
      if (pronto) begin
        idle = 0;
        if (frame.size() == 0) begin
          if (dados == HDR) frame.push_back(dados);
        end else begin
          frame.push_back(dados);
          if (frame.size() == FLEN) begin
            f_op = frame[1]; f_arg = frame[2];
            if (FLEN == 4 && frame[FLEN-1] != (f_op ^ f_arg)) begin
              exp_erro = 1'b1; exp_cod = 2'b01;
            end else if (f_op == 8'h00 || f_op > CMAX) begin
              exp_erro = 1'b1; exp_cod = 2'b00;
            end else if (m_was && !ack) begin
              exp_erro = 1'b1; exp_cod = 2'b11;
            end else begin
              exp_valid = 1'b1; exp_op = f_op; exp_arg = f_arg;
            end
            frame.delete();
          end
        end
      end else if (frame.size() != 0) begin
        idle++;
        if (idle == TOUT) begin
          exp_erro = 1'b1; exp_cod = 2'b10;
          frame.delete();
          idle = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    tests++;
    if (cmd_valid !== exp_valid || erro !== exp_erro ||
        (exp_valid && (cmd_op !== exp_op || cmd_arg !== exp_arg)) ||
        (exp_erro && erro_cod !== exp_cod)) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t: got valid=%b op=%h arg=%h erro=%b cod=%b, want valid=%b op=%h arg=%h erro=%b cod=%b",
               $time, cmd_valid, cmd_op, cmd_arg, erro, erro_cod,
               exp_valid, exp_op, exp_arg, exp_erro, exp_cod);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic cyc(input logic p, input logic [7:0] d, input logic a);
    pronto = p; dados = d; ack = a;
    @(negedge clock);
    pronto = 1'b0; ack = 1'b0;
  endtask

  task automatic frame_send(input logic [7:0] op, input logic [7:0] arg, input logic last_ack);
    cyc(1'b1, HDR, 1'b0);
    cyc(1'b1, op, 1'b0);
    if (FLEN == 4) begin
      cyc(1'b1, arg, 1'b0);
      cyc(1'b1, op ^ arg, last_ack);
    end else begin
      cyc(1'b1, arg, last_ack);
    end
  endtask

  logic [7:0] prev1, prev2, b;

  initial begin
    reset = 1'b1; pronto = 1'b0; ack = 1'b0; dados = 8'h00;
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_arg", cmd_arg, 0);
    check("rst_erro", erro, 0);
    check("rst_cod", erro_cod, 0);
    reset = 1'b0;

    // Valid frame, held until ack
    frame_send(8'h02, 8'h10, 1'b0);
    check("f1_valid", cmd_valid, 1);
    check("f1_op", cmd_op, 8'h02);
    check("f1_arg", cmd_arg, 8'h10);
    check("f1_model_op", exp_op, 8'h02);
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    check("f1_hold", cmd_valid, 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("f1_acked", cmd_valid, 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("ack_idle", cmd_valid, 0);

`ifdef CAFETEIRA_CHECKSUM_EN
    cyc(1'b1, 8'hAA, 1'b0); cyc(1'b1, 8'h02, 1'b0); cyc(1'b1, 8'h10, 1'b0); cyc(1'b1, 8'h13, 1'b0);
    check("chk_erro", erro, 1);
    check("chk_cod", erro_cod, 2'b01);
    check("chk_valid", cmd_valid, 0);
    cyc(1'b0, 8'h00, 1'b0);
    check("chk_pulse", erro, 0);
`endif

    // Garbage before header, then illegal opcode
    cyc(1'b1, 8'h55, 1'b0);
    check("junk_no_err", erro, 0);
    frame_send(8'h07, 8'h00, 1'b0);
    check("ill_erro", erro, 1);
    check("ill_cod", erro_cod, 2'b00);
    check("ill_valid", cmd_valid, 0);

    // Timeout after 20 idle cycles mid-frame
    cyc(1'b1, HDR, 1'b0); cyc(1'b1, 8'h02, 1'b0);
    repeat (TOUT - 1) cyc(1'b0, 8'h00, 1'b0);
    check("to_early", erro, 0);
    cyc(1'b0, 8'h00, 1'b0);
    check("to_erro", erro, 1);
    check("to_cod", erro_cod, 2'b10);
    check("to_model", exp_cod, 2'b10);
    frame_send(8'h01, 8'h00, 1'b0);
    check("to_after_valid", cmd_valid, 1);
    check("to_after_op", cmd_op, 8'h01);
    cyc(1'b0, 8'h00, 1'b1);

    // Overrun, then ack on completion
    frame_send(8'h03, 8'h44, 1'b0);
    frame_send(8'h04, 8'h55, 1'b0);
    check("ovr_erro", erro, 1);
    check("ovr_cod", erro_cod, 2'b11);
    check("ovr_op", cmd_op, 8'h03);
    check("ovr_arg", cmd_arg, 8'h44);
    frame_send(8'h04, 8'h55, 1'b1);
    check("ackc_erro", erro, 0);
    check("ackc_valid", cmd_valid, 1);
    check("ackc_op", cmd_op, 8'h04);
    check("ackc_arg", cmd_arg, 8'h55);
    cyc(1'b0, 8'h00, 1'b1);

    // Reset mid-frame
    cyc(1'b1, HDR, 1'b0); cyc(1'b1, 8'h02, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 8'h10, 1'b1);
    reset = 1'b0;
    check("mrst_erro", erro, 0);
    check("mrst_valid", cmd_valid, 0);
    cyc(1'b0, 8'h00, 1'b0);
    check("mrst_erro2", erro, 0);
    frame_send(8'h05, 8'h77, 1'b0);
    check("mrst_valid2", cmd_valid, 1);
    check("mrst_op", cmd_op, 8'h05);
    check("mrst_arg", cmd_arg, 8'h77);

    // Random traffic; per-cycle comparison does the checking
    prev1 = 8'h00; prev2 = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 150) begin
        repeat (TOUT + 3) cyc(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
      end
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: b = HDR;
        3, 4, 5: b = 8'($urandom_range(0, 7));
        6, 7:    b = prev1 ^ prev2;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) < 5) begin
        cyc(1'b1, b, ($urandom_range(0, 3) == 0));
        prev2 = prev1; prev1 = b;
      end else begin
        cyc(1'b0, b, ($urandom_range(0, 3) == 0));
      end
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
